// File: rtl/pipelined_control_unit.sv
// Registered RV32I major-opcode decoder with a 2-entry skid buffer, flush and illegal-opcode tracking.
// Optional retired branch/memory performance counters are enabled by defining CU_PERF_CNT_EN.
module pipelined_control_unit #(
  parameter int INSTR_W   = 32,
  parameter int PC_W      = 32,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   in_instr,
  input  logic [PC_W-1:0]      in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [10:0]          out_ctrl,
  output logic [INSTR_W-1:0]   out_instr,
  output logic [PC_W-1:0]      out_pc,
  output logic                 out_illegal,
  output logic                 ill_seen,
  output logic [ILL_CNT_W-1:0] ill_cnt,
  output logic [31:0]          perf_branch_cnt,
  output logic [31:0]          perf_mem_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [10:0]          head_ctrl_q, head_ctrl_d;
  logic [INSTR_W-1:0]   head_instr_q, head_instr_d;
  logic [PC_W-1:0]      head_pc_q, head_pc_d;
  logic                 head_ill_q, head_ill_d;
  logic [10:0]          skid_ctrl_q, skid_ctrl_d;
  logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]      skid_pc_q, skid_pc_d;
  logic                 skid_ill_q, skid_ill_d;
  logic                 ill_seen_q, ill_seen_d;
  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  logic [10:0] dec_ctrl;
  logic        dec_ill;
  logic        accept;
  logic        pop;

  always_comb begin
    dec_ctrl = '0;
    dec_ill  = 1'b0;
    case (in_instr[6:0])
      7'b0110011: dec_ctrl = 11'h011;
      7'b0010011: dec_ctrl = 11'h013;
      7'b0000011: dec_ctrl = 11'h063;
      7'b0100011: dec_ctrl = 11'h006;
      7'b1100011: dec_ctrl = 11'h088;
      7'b1101111: dec_ctrl = 11'h501;
      7'b1100111: dec_ctrl = 11'h403;
      7'b0110111: dec_ctrl = 11'h203;
      7'b0010111: dec_ctrl = 11'h303;
      default:    dec_ill  = 1'b1;
    endcase
  end

  // Both handshakes derive only from the occupancy register, so in_ready has no path from out_ready.
  assign in_ready    = (state_q != FULL);
  assign out_valid   = (state_q != EMPTY);
  assign accept      = in_valid && in_ready && !flush;
  assign pop         = out_valid && out_ready;
  assign out_ctrl    = out_valid ? head_ctrl_q : '0;
  assign out_instr   = head_instr_q;
  assign out_pc      = head_pc_q;
  assign out_illegal = head_ill_q;
  assign ill_seen    = ill_seen_q;
  assign ill_cnt     = ill_cnt_q;

  always_comb begin
    state_d      = state_q;
    head_ctrl_d  = head_ctrl_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    head_ill_d   = head_ill_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_ill_d   = skid_ill_q;
    ill_seen_d   = ill_seen_q;
    ill_cnt_d    = ill_cnt_q;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            head_ctrl_d  = dec_ctrl;
            head_instr_d = in_instr;
            head_pc_d    = in_pc;
            head_ill_d   = dec_ill;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_ctrl_d  = dec_ctrl;
            head_instr_d = in_instr;
            head_pc_d    = in_pc;
            head_ill_d   = dec_ill;
          end else if (accept) begin
            skid_ctrl_d  = dec_ctrl;
            skid_instr_d = in_instr;
            skid_pc_d    = in_pc;
            skid_ill_d   = dec_ill;
            state_d      = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_ctrl_d  = skid_ctrl_q;
            head_instr_d = skid_instr_q;
            head_pc_d    = skid_pc_q;
            head_ill_d   = skid_ill_q;
            state_d      = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    if (accept && dec_ill) begin
      ill_seen_d = 1'b1;
      if (ill_cnt_q != '1) ill_cnt_d = ill_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      head_ctrl_q  <= '0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      head_ill_q   <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_ill_q   <= 1'b0;
      ill_seen_q   <= 1'b0;
      ill_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      head_ctrl_q  <= head_ctrl_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      head_ill_q   <= head_ill_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_ill_q   <= skid_ill_d;
      ill_seen_q   <= ill_seen_d;
      ill_cnt_q    <= ill_cnt_d;
    end
  end

`ifdef CU_PERF_CNT_EN
  logic [31:0] perf_branch_q, perf_branch_d;
  logic [31:0] perf_mem_q, perf_mem_d;

  // A pop coinciding with flush is still a completed handshake and is counted.
  always_comb begin
    perf_branch_d = perf_branch_q;
    perf_mem_d    = perf_mem_q;
    if (pop && out_ctrl[7])                 perf_branch_d = perf_branch_q + 32'd1;
    if (pop && (out_ctrl[6] || out_ctrl[2])) perf_mem_d   = perf_mem_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branch_q <= '0;
      perf_mem_q    <= '0;
    end else begin
      perf_branch_q <= perf_branch_d;
      perf_mem_q    <= perf_mem_d;
    end
  end

  assign perf_branch_cnt = perf_branch_q;
  assign perf_mem_cnt    = perf_mem_q;
`else
  assign perf_branch_cnt = '0;
  assign perf_mem_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the decoder and buffer.
module tb_pipelined_control_unit;
  localparam int INSTR_W   = 32;
  localparam int PC_W      = 32;
  localparam int ILL_CNT_W = 8;
  localparam int ILL_MAX   = (1 << ILL_CNT_W) - 1;
`ifdef CU_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [INSTR_W-1:0]   in_instr;
  logic [PC_W-1:0]      in_pc;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [10:0]          out_ctrl;
  logic [INSTR_W-1:0]   out_instr;
  logic [PC_W-1:0]      out_pc;
  logic                 out_illegal;
  logic                 ill_seen;
  logic [ILL_CNT_W-1:0] ill_cnt;
  logic [31:0]          perf_branch_cnt;
  logic [31:0]          perf_mem_cnt;

  pipelined_control_unit #(
    .INSTR_W  (INSTR_W),
    .PC_W     (PC_W),
    .ILL_CNT_W(ILL_CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_pc          (in_pc),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ctrl       (out_ctrl),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_illegal    (out_illegal),
    .ill_seen       (ill_seen),
    .ill_cnt        (ill_cnt),
    .perf_branch_cnt(perf_branch_cnt),
    .perf_mem_cnt   (perf_mem_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0]        ctrl;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               ill;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_ill_cnt;
  bit          m_ill_seen;
  logic [31:0] m_pb, m_pm;
  int          n_checks;
  int          n_errors;

  logic [6:0] legal_ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  // Reference decode straight from the opcode table: {illegal, ctrl}
  function automatic logic [11:0] ref_dec(input logic [6:0] op);
    case (op)
      7'b0110011: return {1'b0, 11'h011};
      7'b0010011: return {1'b0, 11'h013};
      7'b0000011: return {1'b0, 11'h063};
      7'b0100011: return {1'b0, 11'h006};
      7'b1100011: return {1'b0, 11'h088};
      7'b1101111: return {1'b0, 11'h501};
      7'b1100111: return {1'b0, 11'h403};
      7'b0110111: return {1'b0, 11'h203};
      7'b0010111: return {1'b0, 11'h303};
      default:    return {1'b1, 11'h000};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ill_cnt  = 0;
    m_ill_seen = 1'b0;
    m_pb       = '0;
    m_pm       = '0;
  endtask

  task automatic check_outs();
    check("out_valid", out_valid, mq.size() > 0);
    check("in_ready", in_ready, mq.size() < 2);
    if (mq.size() > 0) begin
      check("out_ctrl", out_ctrl, mq[0].ctrl);
      check("out_instr", out_instr, mq[0].instr);
      check("out_pc", out_pc, mq[0].pc);
      check("out_illegal", out_illegal, mq[0].ill);
    end else begin
      check("bubble_ctrl", out_ctrl, 11'h000);
    end
    check("ill_seen", ill_seen, m_ill_seen);
    check("ill_cnt", ill_cnt, m_ill_cnt);
    check("perf_branch", perf_branch_cnt, PERF ? m_pb : 32'd0);
    check("perf_mem", perf_mem_cnt, PERF ? m_pm : 32'd0);
  endtask

  // Check current outputs, advance the model by one clock using the present inputs, then clock.
  task automatic tick();
    bit          acc;
    bit          pop;
    ent_t        e;
    logic [11:0] d;
    check_outs();
    if (rst) begin
      model_reset();
    end else begin
      acc = in_valid && (mq.size() < 2) && !flush;
      pop = (mq.size() > 0) && out_ready;
      if (pop) begin
        if (mq[0].ctrl[7]) m_pb = m_pb + 32'd1;
        if (mq[0].ctrl[6] || mq[0].ctrl[2]) m_pm = m_pm + 32'd1;
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (pop) void'(mq.pop_front());
        if (acc) begin
          d       = ref_dec(in_instr[6:0]);
          e.ctrl  = d[10:0];
          e.ill   = d[11];
          e.instr = in_instr;
          e.pc    = in_pc;
          mq.push_back(e);
          if (e.ill) begin
            m_ill_seen = 1'b1;
            if (m_ill_cnt < ILL_MAX) m_ill_cnt++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic ordy);
    rst       = 1'b0;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    flush     = fl;
    out_ready = ordy;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_ready"}, in_ready, 1'b1);
    check({tag, "_ctrl"}, out_ctrl, 11'h000);
    check({tag, "_instr"}, out_instr, 32'd0);
    check({tag, "_pc"}, out_pc, 32'd0);
    check({tag, "_ill"}, out_illegal, 1'b0);
    check({tag, "_seen"}, ill_seen, 1'b0);
    check({tag, "_cnt"}, ill_cnt, 8'd0);
    check({tag, "_pb"}, perf_branch_cnt, 32'd0);
    check({tag, "_pm"}, perf_mem_cnt, 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(3) != 0) r[6:0] = legal_ops[$urandom_range(8)];
    return r;
  endfunction

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");

    // addi: one-cycle latency
    drive(1'b1, 32'h00A00093, 32'h100, 1'b0, 1'b1);
    check("addi_ctrl", out_ctrl, 11'h013);
    check("addi_pc", out_pc, 32'h100);
    check("addi_ill", out_illegal, 1'b0);

    // lw, sw, beq, jal streamed back to back
    drive(1'b1, 32'h0002A303, 32'h104, 1'b0, 1'b1);
    check("lw_ctrl", out_ctrl, 11'h063);
    drive(1'b1, 32'h0062A023, 32'h108, 1'b0, 1'b1);
    check("sw_ctrl", out_ctrl, 11'h006);
    drive(1'b1, 32'h00000463, 32'h10C, 1'b0, 1'b1);
    check("beq_ctrl", out_ctrl, 11'h088);
    drive(1'b1, 32'h008000EF, 32'h110, 1'b0, 1'b1);
    check("jal_ctrl", out_ctrl, 11'h501);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // stall: lui then auipc with out_ready low
    drive(1'b1, 32'h123452B7, 32'h200, 1'b0, 1'b0);
    drive(1'b1, 32'h00001297, 32'h204, 1'b0, 1'b0);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_ctrl", out_ctrl, 11'h203);
    drive(1'b1, 32'h00000013, 32'h208, 1'b0, 1'b0);
    check("stall_hold", out_ctrl, 11'h203);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("release_ctrl", out_ctrl, 11'h303);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("release_empty", out_valid, 1'b0);

    // flush while FULL with an incoming instruction
    drive(1'b1, 32'h00000033, 32'h300, 1'b0, 1'b0);
    drive(1'b1, 32'h00000063, 32'h304, 1'b0, 1'b0);
    drive(1'b1, 32'h0000006F, 32'h308, 1'b1, 1'b0);
    check("flush_valid", out_valid, 1'b0);
    check("flush_ready", in_ready, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // illegal opcode flood: counter saturates
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, {$urandom} | 32'h7F, 32'h400 + 32'(i * 4), 1'b0, 1'b1);
      if (i % 50 == 0) check("ill_out", out_illegal, 1'b1);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("ill_sat", ill_cnt, 8'd255);
    check("ill_sticky", ill_seen, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    check("ill_after_flush", ill_cnt, 8'd255);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(3) != 0, rand_instr(), $urandom,
            $urandom_range(15) == 0, $urandom_range(2) != 0);
    end

    // perf scenario after a fresh reset, then reset mid-stream
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] ins;
      ins = (i < 5) ? 32'h00000463 : (i < 8) ? 32'h0002A303 : 32'h0062A023;
      drive(1'b1, ins, 32'h800 + 32'(i * 4), 1'b0, 1'b1);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("perf_branch_5", perf_branch_cnt, PERF ? 32'd5 : 32'd0);
    check("perf_mem_5", perf_mem_cnt, PERF ? 32'd5 : 32'd0);
    drive(1'b1, 32'h0000007F, 32'h900, 1'b0, 1'b0);
    drive(1'b1, 32'h00000463, 32'h904, 1'b0, 1'b0);
    in_valid = 1'b1;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check_all_zero("midrst");
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Registered successor to the combinational opcode decoder: decodes the full 7-bit RV32I major opcode into an extended control word.
- Decode result, PC and instruction are carried in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Sits between the fetch stage and the ID/EX register. Supports stall (downstream back-pressure) and flush (branch/jump redirect).
- Detects and counts illegal opcodes.

Parameters:
INSTR_W, 32, instruction width; opcode is instr[6:0]; INSTR_W >= 7.
PC_W, 32, program-counter width carried alongside the instruction.
ILL_CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  fetch presents an instruction.
in_ready  output  1  unit can accept an instruction this cycle.
in_instr  input  INSTR_W  instruction word.
in_pc  input  PC_W  PC of in_instr.
flush  input  1  discard all held and incoming instructions.
out_valid  output  1  decoded entry available.
out_ready  input  1  downstream accepts the entry.
out_ctrl  output  11  {jump, upper, pc_a, branch, dmemread, dmemtoreg, aluop[1:0], dmemwrite, alusrc, regwrite}.
out_instr  output  INSTR_W  instruction of the head entry.
out_pc  output  PC_W  PC of the head entry.
out_illegal  output  1  head entry has an illegal opcode.
ill_seen  output  1  sticky: any illegal opcode accepted since reset.
ill_cnt  output  ILL_CNT_W  saturating count of accepted illegal opcodes.
perf_branch_cnt  output  32  branches retired to downstream (CU_PERF_CNT_EN).
perf_mem_cnt  output  32  loads and stores retired to downstream (CU_PERF_CNT_EN).

Behaviour:
- Decode is combinational on in_instr[6:0]; its result is registered together with the PC and instruction.
- Decode table (out_ctrl, hex):
  - 0110011 R-type: 0x011
  - 0010011 I-arith: 0x013
  - 0000011 load: 0x063
  - 0100011 store: 0x006
  - 1100011 branch: 0x088
  - 1101111 jal: 0x501
  - 1100111 jalr: 0x403
  - 0110111 lui: 0x203
  - 0010111 auipc: 0x303
  - any other opcode, including opcode[1:0] != 2'b11: ctrl 0x000 and illegal=1.
- Storage: head register (drives the outputs) and skid register.
- States by occupancy: EMPTY (0), ONE (head valid), FULL (head and skid valid).
- in_ready = !skid_valid, taken from a register with no combinational path from out_ready.
- Accept occurs when in_valid & in_ready & !flush. Pop occurs when out_valid & out_ready.
- Transitions:
  - EMPTY + accept -> ONE. Latency is 1 cycle: out_valid rises on the cycle after acceptance.
  - ONE + accept + pop -> ONE, head loads the new entry.
  - ONE + accept, no pop -> FULL, new entry goes to skid.
  - ONE + pop, no accept -> EMPTY.
  - FULL + pop -> ONE, skid moves to head. No accept is possible while FULL.
- Order is strictly FIFO; no entry is duplicated or dropped except by flush.
- Flush has priority over all other events:
  - Next cycle: head and skid both invalid, out_valid=0, in_ready=1.
  - An instruction presented in the flush cycle is discarded and not counted.
  - A pop in the flush cycle still counts as a completed handshake.
- out_ctrl, out_instr, out_pc and out_illegal hold their values while out_valid & !out_ready (stable under stall).
- When out_valid=0, out_ctrl is forced to 0x000 so downstream sees a bubble.
- Illegal tracking:
  - On accept of an illegal opcode: ill_seen <= 1; ill_cnt increments and saturates at all-ones.
  - ill_seen and ill_cnt are cleared only by rst; flush does not clear them.
- Reset (rst=1 on a rising clk edge, including mid-operation): both entries invalid, out_valid=0, out_ctrl=0, out_instr=0, out_pc=0, out_illegal=0, ill_seen=0, ill_cnt=0, perf counters=0. in_ready=1 from the first cycle after reset.

Optional Feature:
- Macro: CU_PERF_CNT_EN.
- Defined:
  - perf_branch_cnt increments on each pop whose out_ctrl[7]=1.
  - perf_mem_cnt increments on each pop with out_ctrl[6]|out_ctrl[2].
  - Both are 32-bit and wrap modulo 2^32; only rst clears them.
- Undefined: both ports are tied to 0 and no counter flops are instantiated.

Test Plan:
- Reset, then in_valid=1 with instr=0x00A00093 (addi), pc=0x100, out_ready=1 -> next cycle out_valid=1, out_ctrl=0x013, out_pc=0x100, out_illegal=0.
- Stream lw (0x0002A303), sw (0x0062A023), beq (0x00000463), jal (0x008000EF), out_ready=1 -> out_ctrl 0x063, 0x006, 0x088, 0x501 on consecutive cycles, one per clk.
- out_ready=0 for 3 cycles while feeding lui then auipc:
  - in_ready falls after 2 accepts; out_ctrl holds 0x203.
  - Releasing out_ready yields 0x203 then 0x303, each exactly once.
- FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed instruction never appears at the output.
- Feed opcode 0x7F 300 times (ILL_CNT_W=8) -> out_illegal=1 and out_ctrl=0x000 each time; ill_seen=1; ill_cnt saturates at 255.
- CU_PERF_CNT_EN defined, 5 branches + 3 loads + 2 stores popped, then rst mid-stream -> perf_branch_cnt=5 and perf_mem_cnt=5 before reset; all outputs 0 after reset.
